alu_seq: RTL and testbench

Parametrised, handshaked successor to the team's 8-bit combinational ALU. It has a configurable datapath width and a registered result with status flags. It adds an iterative shift-add multiplier and rotate operations, and uses valid/ready flow control on both the operand and result sides. It sits between an operand-issue stage and a writeback stage, and holds its result stable under downstream backpressure.

---
 rtl/alu_seq_if.sv | 29 ++
 rtl/alu_seq.sv | 209 ++++++++++++++++++++
 tb/tb_alu_seq.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// Operand-issue / writeback handshake bundle for alu_seq.
// The slave modport is the ALU's view; the master modport is the surrounding pipeline.
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             flag_z;
  logic             flag_n;
  logic             flag_c;
  logic             flag_v;
  logic             flag_err;

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, flag_z, flag_n, flag_c, flag_v, flag_err
  );

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, flag_z, flag_n, flag_c, flag_v, flag_err
  );
endinterface

// File: rtl/alu_seq.sv
// Handshaked ALU with a one-entry registered result/flag slot.
// Multiplies run as WIDTH shift-add iterations; everything else completes at the accept edge.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  alu_seq_if.slave   io_bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] w_acc_nxt;
  logic [WIDTH-1:0]   r_mb;
  logic               r_mul_hi;

  logic               w_in_ready;
  logic               w_accept;
  logic               w_mul_op;
  logic               w_mul_done;
  logic               w_load;
  logic               w_drain;

  logic [WIDTH-1:0]   w_res;
  logic               w_c;
  logic               w_v;
  logic               w_err;
  logic [WIDTH-1:0]   w_ld_res;
  logic               w_ld_z;
  logic               w_ld_n;
  logic               w_ld_c;
  logic               w_ld_v;
  logic               w_ld_err;

  logic [WIDTH-1:0]   r_result;
  logic               r_out_valid;
  logic               r_z;
  logic               r_n;
  logic               r_c;
  logic               r_v;
  logic               r_err;

  // Accepting only when the slot is empty or draining means a multiply never completes into a full slot.
  assign w_in_ready = !i_rst && (r_state == ST_IDLE) && (!r_out_valid || io_bus.out_ready);
  assign w_accept   = io_bus.in_valid && w_in_ready;
  assign w_mul_op   = (io_bus.op == 4'b1000) || (io_bus.op == 4'b1001);
  assign w_mul_done = (r_state == ST_MUL) && (r_cnt == CW'(WIDTH - 1));
  assign w_acc_nxt  = r_acc + (r_mb[0] ? r_mcand : {(2*WIDTH){1'b0}});
  assign w_load     = w_mul_done || (w_accept && !w_mul_op);
  assign w_drain    = r_out_valid && io_bus.out_ready;

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && w_mul_op) begin
          w_state_nxt = ST_MUL;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_MUL: begin
        if (w_mul_done) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_MUL;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Shift-add multiplier datapath: one bit of b per cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt    <= {CW{1'b0}};
      r_acc    <= {(2*WIDTH){1'b0}};
      r_mcand  <= {(2*WIDTH){1'b0}};
      r_mb     <= {WIDTH{1'b0}};
      r_mul_hi <= 1'b0;
    end else if (w_accept && w_mul_op) begin
      r_cnt    <= {CW{1'b0}};
      r_acc    <= {(2*WIDTH){1'b0}};
      r_mcand  <= {{WIDTH{1'b0}}, io_bus.a};
      r_mb     <= io_bus.b;
      r_mul_hi <= io_bus.op[0];
    end else if (r_state == ST_MUL) begin
      r_cnt    <= w_mul_done ? {CW{1'b0}} : (r_cnt + CW'(1));
      r_acc    <= w_acc_nxt;
      r_mcand  <= {r_mcand[2*WIDTH-2:0], 1'b0};
      r_mb     <= {1'b0, r_mb[WIDTH-1:1]};
    end else begin
      r_cnt    <= r_cnt;
    end
  end

  // Single-cycle operation results and carry/overflow.
  always_comb begin
    w_res = {WIDTH{1'b0}};
    w_c   = 1'b0;
    w_v   = 1'b0;
    w_err = 1'b0;
    case (io_bus.op)
      4'b0000: begin
        {w_c, w_res} = {1'b0, io_bus.a} + {1'b0, io_bus.b};
        w_v = (io_bus.a[WIDTH-1] == io_bus.b[WIDTH-1]) && (w_res[WIDTH-1] != io_bus.a[WIDTH-1]);
      end
      4'b0001: begin
        w_res = io_bus.a - io_bus.b;
        w_c   = (io_bus.a < io_bus.b);
        w_v   = (io_bus.a[WIDTH-1] != io_bus.b[WIDTH-1]) && (w_res[WIDTH-1] != io_bus.a[WIDTH-1]);
      end
      4'b0010: w_res = io_bus.a & io_bus.b;
      4'b0011: w_res = io_bus.a | io_bus.b;
      4'b0100: w_res = io_bus.a ^ io_bus.b;
      4'b0101: begin
        w_res = {io_bus.a[WIDTH-2:0], 1'b0};
        w_c   = io_bus.a[WIDTH-1];
      end
      4'b0110: begin
        w_res = {1'b0, io_bus.a[WIDTH-1:1]};
        w_c   = io_bus.a[0];
      end
      4'b0111: w_res = io_bus.a;
      4'b1000: w_res = {WIDTH{1'b0}};
      4'b1001: w_res = {WIDTH{1'b0}};
      4'b1010: begin
        w_res = {io_bus.a[WIDTH-2:0], io_bus.a[WIDTH-1]};
        w_c   = io_bus.a[WIDTH-1];
      end
      4'b1011: begin
        w_res = {io_bus.a[0], io_bus.a[WIDTH-1:1]};
        w_c   = io_bus.a[0];
      end
      default: w_err = 1'b1;
    endcase
  end

  // Select what gets loaded into the output slot: a finishing multiply wins over the IDLE path.
  always_comb begin
    w_ld_res = w_res;
    w_ld_c   = w_c;
    w_ld_v   = w_v;
    w_ld_err = w_err;
    if (w_mul_done) begin
      w_ld_res = r_mul_hi ? w_acc_nxt[2*WIDTH-1:WIDTH] : w_acc_nxt[WIDTH-1:0];
      w_ld_c   = 1'b0;
      w_ld_v   = 1'b0;
      w_ld_err = 1'b0;
    end else begin
      w_ld_res = w_res;
    end
    w_ld_z = (w_ld_res == {WIDTH{1'b0}});
    w_ld_n = w_ld_res[WIDTH-1];
  end

  // One-entry output slot; held unchanged while stalled by the writeback stage.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_out_valid <= 1'b0;
      r_result    <= {WIDTH{1'b0}};
      r_z         <= 1'b0;
      r_n         <= 1'b0;
      r_c         <= 1'b0;
      r_v         <= 1'b0;
      r_err       <= 1'b0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_result    <= w_ld_res;
      r_z         <= w_ld_z;
      r_n         <= w_ld_n;
      r_c         <= w_ld_c;
      r_v         <= w_ld_v;
      r_err       <= w_ld_err;
    end else if (w_drain) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_out_valid;
    end
  end

  assign io_bus.in_ready  = w_in_ready;
  assign io_bus.out_valid = r_out_valid;
  assign io_bus.result    = r_result;
  assign io_bus.flag_z    = r_z;
  assign io_bus.flag_n    = r_n;
  assign io_bus.flag_c    = r_c;
  assign io_bus.flag_v    = r_v;
  assign io_bus.flag_err  = r_err;
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=8: vector table for single-cycle ops,
// hand-written sequences for multiply latency, backpressure and reset-abort.
module tb_alu_seq;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  alu_seq_if #(.WIDTH(8)) bus ();

  alu_seq #(.WIDTH(8)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       z;
    logic       n;
    logic       c;
    logic       v;
    logic       err;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [13:0] obs();
    return {bus.out_valid, bus.result, bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v, bus.flag_err};
  endfunction

  task automatic do_mul(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp, input string name);
    int n;
    bus.in_valid  = 1'b1;
    bus.op        = op;
    bus.a         = a;
    bus.b         = b;
    bus.out_ready = 1'b1;
    #4;
    chk({name, "_accept_ready"}, 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      #4;
      chk({name, "_busy_ready"}, 32'(bus.in_ready), 32'd0);
      tick();
      n++;
    end
    chk({name, "_latency"}, 32'(n), 32'd8);
    chk({name, "_out"}, 32'(obs()),
        32'({1'b1, exp, (exp == 8'h00), exp[7], 1'b0, 1'b0, 1'b0}));
    chk({name, "_ready_back"}, 32'(bus.in_ready), 32'd1);
    tick();
  endtask

  initial begin
    int n;
    checks   = 0;
    failures = 0;
    // op, a, b, result, z, n, c, v, err
    vecs[0]  = '{4'b0000, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{4'b0000, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{4'b0001, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{4'b0001, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{4'b0010, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{4'b0011, 8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{4'b0100, 8'hAA, 8'hAA, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{4'b0101, 8'h81, 8'h00, 8'h02, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{4'b0110, 8'h81, 8'h00, 8'h40, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{4'b0111, 8'h80, 8'h55, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{4'b1010, 8'h81, 8'h00, 8'h03, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{4'b1011, 8'h81, 8'h00, 8'hC0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{4'b1011, 8'h02, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{4'b1101, 8'hFF, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[14] = '{4'b1111, 8'h7F, 8'h80, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.op        = 4'b0000;
    bus.a         = 8'h00;
    bus.b         = 8'h00;
    bus.out_ready = 1'b1;

    // Reset held two cycles.
    tick();
    #4;
    chk("reset_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    rst = 1'b0;
    chk("reset_outputs", 32'(obs()), 32'd0);
    #1;
    chk("reset_release_ready", 32'(bus.in_ready), 32'd1);

    // Back-to-back single-cycle ops, one per cycle.
    for (int i = 0; i < 15; i++) begin
      bus.in_valid = 1'b1;
      bus.op       = vecs[i].op;
      bus.a        = vecs[i].a;
      bus.b        = vecs[i].b;
      #3;
      chk($sformatf("vec%0d_in_ready", i), 32'(bus.in_ready), 32'd1);
      tick();
      chk($sformatf("vec%0d_out", i), 32'(obs()),
          32'({1'b1, vecs[i].res, vecs[i].z, vecs[i].n, vecs[i].c, vecs[i].v, vecs[i].err}));
    end
    bus.in_valid = 1'b0;
    tick();
    chk("drain_empty", 32'(bus.out_valid), 32'd0);

    // Multiplies.
    do_mul(4'b1000, 8'h10, 8'h20, 8'h00, "mul_lo_10x20");
    do_mul(4'b1001, 8'h10, 8'h20, 8'h02, "mul_hi_10x20");
    do_mul(4'b1000, 8'hFF, 8'hFF, 8'h01, "mul_lo_ffxff");
    do_mul(4'b1001, 8'hFF, 8'hFF, 8'hFE, "mul_hi_ffxff");
    do_mul(4'b1001, 8'hB7, 8'h5D, 8'h42, "mul_hi_b7x5d");

    // Backpressure: result frozen, new requests ignored.
    bus.in_valid  = 1'b1;
    bus.op        = 4'b0000;
    bus.a         = 8'h12;
    bus.b         = 8'h34;
    bus.out_ready = 1'b0;
    tick();
    bus.a = 8'h01;
    bus.b = 8'h01;
    for (int i = 0; i < 5; i++) begin
      #4;
      chk($sformatf("bp%0d_in_ready", i), 32'(bus.in_ready), 32'd0);
      chk($sformatf("bp%0d_hold", i), 32'(obs()), 32'({1'b1, 8'h46, 5'b00000}));
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    chk("bp_replace", 32'(obs()), 32'({1'b1, 8'h02, 5'b00000}));
    tick();
    chk("bp_single_drain", 32'(bus.out_valid), 32'd0);

    // Reset three cycles into a multiply abandons it.
    bus.in_valid = 1'b1;
    bus.op       = 4'b1000;
    bus.a        = 8'h03;
    bus.b        = 8'h05;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    #3;
    chk("mulrst_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("mulrst_ready", 32'(bus.in_ready), 32'd1);
    chk("mulrst_outputs", 32'(obs()), 32'd0);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.out_valid) n++;
      tick();
    end
    chk("mulrst_no_result", 32'(n), 32'd0);
    do_mul(4'b1000, 8'h03, 8'h05, 8'h0F, "mul_after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
